// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// port of the unified memory and streams one instruction per cycle to decode.
// A single fetch is kept in flight to cover the memory's registered read.
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'd1,
    parameter logic [11:0] PC_MAX   = 12'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_stall,
    input  logic        I_redirect,
    input  logic [11:0] I_target,
    input  logic [31:0] I_mem_instr,
    output logic [11:0] O_mem_addr,
    output logic        O_fetch_en,
    output logic [31:0] O_instr,
    output logic [11:0] O_pc,
    output logic        O_valid
);

    // Fetch-side state
    logic [11:0] r_fetch_pc;
    logic        r_inflight;
    logic [11:0] r_inflight_pc;

    // Decode-side output registers
    logic [31:0] r_instr;
    logic [11:0] r_pc;
    logic        r_valid;

    // Combinational memory request
    logic [11:0] w_mem_addr;
    logic        w_fetch_en;

    // Sequential successor within the instruction region, wrapping at PC_MAX.
    function automatic logic [11:0] next_pc(input logic [11:0] a);
        next_pc = (a == PC_MAX) ? 12'd0 : a + 12'd1;
    endfunction

    // Memory request: redirect target, held address during a stall, else fetch_pc.
    always_comb begin
        w_mem_addr = r_fetch_pc;
        w_fetch_en = 1'b0;
        if (rst) begin
            w_fetch_en = 1'b0;
        end else if (I_redirect) begin
            w_mem_addr = I_target;
            w_fetch_en = 1'b1;
        end else if (I_stall) begin
            // Re-present the outstanding address so a memory enable raised by
            // the data port reloads the same word instead of a new one.
            w_mem_addr = r_inflight ? r_inflight_pc : r_fetch_pc;
            w_fetch_en = 1'b0;
        end else begin
            w_mem_addr = r_fetch_pc;
            w_fetch_en = 1'b1;
        end
    end

    // PC / in-flight tracking and output capture; redirect beats stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 12'd0;
            r_instr       <= 32'd0;
            r_pc          <= 12'd0;
            r_valid       <= 1'b0;
        end else if (I_redirect) begin
            // The outstanding word belongs to the wrong path and is dropped.
            r_fetch_pc    <= next_pc(I_target);
            r_inflight    <= 1'b1;
            r_inflight_pc <= I_target;
            r_valid       <= 1'b0;
        end else if (!I_stall) begin
            r_fetch_pc    <= next_pc(r_fetch_pc);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            if (r_inflight) begin
                r_instr <= I_mem_instr;
                r_pc    <= r_inflight_pc;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign O_mem_addr = w_mem_addr;
    assign O_fetch_en = w_fetch_en;
    assign O_instr    = r_instr;
    assign O_pc       = r_pc;
    assign O_valid    = r_valid;

endmodule
